// File: rtl/serial_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bus_arbiter
//  Description : Round-robin arbiter for the shared serial bus. Grants one
//                master at a time, deserialises its slave-select stream into
//                a one-hot slave enable, and releases the bus on completion,
//                abandon, decode error or watchdog expiry.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int MASTER_IDX_LEN = 1,
    parameter int SLAVE_LEN      = 2,
    parameter int NUM_SLAVES     = 3,
    parameter int TIMEOUT        = 1000,
    parameter int TIMEOUT_LEN    = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    approval_request,
    input  logic [NUM_MASTERS-1:0]    trans_done,
    input  logic [NUM_MASTERS-1:0]    tx_slave_select,
    output logic [NUM_MASTERS-1:0]    approval_grant,
    output logic                      arbitor_busy,
    output logic                      bus_busy,
    output logic [MASTER_IDX_LEN-1:0] master_sel,
    output logic [NUM_SLAVES-1:0]     slave_sel,
    output logic                      slave_sel_valid,
    output logic                      timeout,
    output logic                      decode_err
);

    localparam int                      CNT_W        = $clog2(SLAVE_LEN + 1);
    localparam logic [CNT_W-1:0]        LAST_BIT     = CNT_W'(SLAVE_LEN - 1);
    localparam logic [SLAVE_LEN:0]      NUM_SLAVES_C = (SLAVE_LEN + 1)'(NUM_SLAVES);
    localparam bit                      WD_EN        = (TIMEOUT != 0);
    localparam logic [TIMEOUT_LEN-1:0]  WD_LAST      = (TIMEOUT == 0) ? '0 : TIMEOUT_LEN'(TIMEOUT - 1);
    localparam logic [TIMEOUT_LEN-1:0]  WD_MAX       = '1;
    localparam logic [MASTER_IDX_LEN-1:0] LAST_MASTER = MASTER_IDX_LEN'(NUM_MASTERS - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GRANT   = 3'd1;
    localparam logic [2:0] ST_SSEL    = 3'd2;
    localparam logic [2:0] ST_CONNECT = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    logic [2:0]                state_q, state_d;
    logic [NUM_MASTERS-1:0]    grant_q, grant_d;
    logic [MASTER_IDX_LEN-1:0] master_sel_q, master_sel_d;
    logic [NUM_SLAVES-1:0]     slave_sel_q, slave_sel_d;
    logic                      ssv_q, ssv_d;
    logic                      arb_busy_q, arb_busy_d;
    logic                      bus_busy_q, bus_busy_d;
    logic                      timeout_q, timeout_d;
    logic                      decode_err_q, decode_err_d;
    logic [MASTER_IDX_LEN-1:0] ptr_q, ptr_d;
    logic [SLAVE_LEN-1:0]      slave_id_q, slave_id_d;
    logic [CNT_W-1:0]          bitcnt_q, bitcnt_d;
    logic [TIMEOUT_LEN-1:0]    wd_q, wd_d;

    logic                      w_any_req;
    logic                      w_own_req;
    logic                      w_own_done;
    logic                      w_last_bit;
    logic [SLAVE_LEN-1:0]      w_id_next;
    logic                      w_id_ok;
    logic                      w_wd_expire;
    logic [MASTER_IDX_LEN-1:0] w_rr_winner;

    // Index of the candidate j positions above the pointer, wrapping at NUM_MASTERS.
    function automatic logic [MASTER_IDX_LEN-1:0] rr_idx(input logic [MASTER_IDX_LEN-1:0] p,
                                                         input int j);
        int s;
        s = int'(p) + j;
        if (s >= NUM_MASTERS) begin
            s = s - NUM_MASTERS;
        end
        return MASTER_IDX_LEN'(s);
    endfunction

    assign w_any_req   = |approval_request;
    assign w_own_req   = approval_request[master_sel_q];
    assign w_own_done  = trans_done[master_sel_q];
    assign w_last_bit  = (bitcnt_q == LAST_BIT);
    assign w_id_next   = (slave_id_q << 1) | SLAVE_LEN'(tx_slave_select[master_sel_q]);
    assign w_id_ok     = ({1'b0, w_id_next} < NUM_SLAVES_C);
    assign w_wd_expire = WD_EN && (wd_q == WD_LAST);

    // Round-robin search: scanning from farthest to nearest lets the nearest requester win.
    always_comb begin
        w_rr_winner = '0;
        for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
            if (approval_request[rr_idx(ptr_q, j)]) begin
                w_rr_winner = rr_idx(ptr_q, j);
            end
        end
    end

    // State and registered outputs; reset drops the bus immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            master_sel_q <= '0;
            slave_sel_q  <= '0;
            ssv_q        <= 1'b0;
            arb_busy_q   <= 1'b0;
            bus_busy_q   <= 1'b0;
            timeout_q    <= 1'b0;
            decode_err_q <= 1'b0;
            ptr_q        <= '0;
            slave_id_q   <= '0;
            bitcnt_q     <= '0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            master_sel_q <= master_sel_d;
            slave_sel_q  <= slave_sel_d;
            ssv_q        <= ssv_d;
            arb_busy_q   <= arb_busy_d;
            bus_busy_q   <= bus_busy_d;
            timeout_q    <= timeout_d;
            decode_err_q <= decode_err_d;
            ptr_q        <= ptr_d;
            slave_id_q   <= slave_id_d;
            bitcnt_q     <= bitcnt_d;
            wd_q         <= wd_d;
        end
    end

    // Next-state logic; losing the owner's request aborts from any active state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (w_any_req) state_d = ST_GRANT;
            ST_GRANT:   state_d = w_own_req ? ST_SSEL : ST_RELEASE;
            ST_SSEL: begin
                if (!w_own_req) begin
                    state_d = ST_RELEASE;
                end else if (w_last_bit) begin
                    state_d = w_id_ok ? ST_CONNECT : ST_RELEASE;
                end
            end
            ST_CONNECT: if (w_own_done || !w_own_req || w_wd_expire) state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath counters.
    always_comb begin
        grant_d      = grant_q;
        master_sel_d = master_sel_q;
        slave_sel_d  = slave_sel_q;
        ssv_d        = ssv_q;
        ptr_d        = ptr_q;
        slave_id_d   = slave_id_q;
        bitcnt_d     = bitcnt_q;
        wd_d         = wd_q;
        timeout_d    = 1'b0;
        decode_err_d = 1'b0;
        arb_busy_d   = (state_d != ST_IDLE);
        bus_busy_d   = (state_d == ST_CONNECT);
        case (state_q)
            ST_IDLE: begin
                if (w_any_req) begin
                    grant_d      = NUM_MASTERS'(1) << w_rr_winner;
                    master_sel_d = w_rr_winner;
                end
            end
            ST_GRANT: begin
                bitcnt_d   = '0;
                slave_id_d = '0;
            end
            ST_SSEL: begin
                slave_id_d = w_id_next;
                bitcnt_d   = bitcnt_q + CNT_W'(1);
                if (w_own_req && w_last_bit) begin
                    if (w_id_ok) begin
                        slave_sel_d = NUM_SLAVES'(1) << w_id_next;
                        ssv_d       = 1'b1;
                        wd_d        = '0;
                    end else begin
                        decode_err_d = 1'b1;
                    end
                end
            end
            ST_CONNECT: begin
                if (wd_q != WD_MAX) begin
                    wd_d = wd_q + TIMEOUT_LEN'(1);
                end
                // Completion or abandon on the same edge suppresses the timeout flag.
                if (!w_own_done && w_own_req && w_wd_expire) begin
                    timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (state_d == ST_RELEASE) begin
            grant_d     = '0;
            slave_sel_d = '0;
            ssv_d       = 1'b0;
            ptr_d       = (master_sel_q == LAST_MASTER) ? '0 : master_sel_q + MASTER_IDX_LEN'(1);
        end
    end

    assign approval_grant  = grant_q;
    assign arbitor_busy    = arb_busy_q;
    assign bus_busy        = bus_busy_q;
    assign master_sel      = master_sel_q;
    assign slave_sel       = slave_sel_q;
    assign slave_sel_valid = ssv_q;
    assign timeout         = timeout_q;
    assign decode_err      = decode_err_q;

endmodule
`default_nettype wire
